hours_segment_decoder: RTL and testbench

HOURS_SEGMENT_DECODER -- requirements
Module: hours_segment_decoder

---
 rtl/hours_segment_decoder_if.sv | 26 ++
 rtl/hours_segment_decoder.sv | 134 +++++++++++++
 tb/tb_hours_segment_decoder.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/hours_segment_decoder_if.sv
// Handshake bundle for hours_segment_decoder.
//   seg_in    : two-digit active-low 7-segment pattern {tens, units}, abcdefg
//   sample_en : one-cycle strobe qualifying seg_in
//   out_ready : consumer ready
//   out_valid : hours_bcd holds a newly accepted value
//   hours_bcd : decoded hours 0..12
//   err       : level flag, a stable illegal pattern was accepted
// master = producer/consumer side (testbench), slave = decoder.
interface hours_segment_decoder_if;
    logic [13:0] seg_in;
    logic        sample_en;
    logic        out_ready;
    logic        out_valid;
    logic [3:0]  hours_bcd;
    logic        err;

    modport master (
        output seg_in, sample_en, out_ready,
        input  out_valid, hours_bcd, err
    );

    modport slave (
        input  seg_in, sample_en, out_ready,
        output out_valid, hours_bcd, err
    );
endinterface

// File: rtl/hours_segment_decoder.sv
// Debounces and decodes a two-digit 7-segment hours display (0..12).
// A pattern is accepted once STABLE_CNT consecutive identical samples have
// been captured; a legal, new value is presented with a valid/ready
// handshake, an illegal one raises err.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : hours_segment_decoder_if.slave (seg_in, sample_en, out_ready,
//           out_valid, hours_bcd, err)
module hours_segment_decoder #(
    parameter int unsigned STABLE_CNT = 3
) (
    input logic                     clk,
    input logic                     rst_n,
    hours_segment_decoder_if.slave  bus
);

    localparam logic [3:0] STABLE_CNT4 = 4'(STABLE_CNT);

    typedef enum logic [1:0] {IDLE, TRACK, PRESENT} state_t;

    state_t      state_q, state_d;
    logic [13:0] sample_q, sample_d;
    logic [3:0]  stab_cnt_q, stab_cnt_d;
    logic        out_valid_q, out_valid_d;
    logic [3:0]  hours_q, hours_d;
    logic        err_q, err_d;
    logic [3:0]  last_q, last_d;
    logic        have_last_q, have_last_d;

    // Returns {ok, digit}; ok=0 for any pattern that is not a decimal digit.
    function automatic logic [4:0] dec_digit(input logic [6:0] p);
        case (p)
            7'b0000001: dec_digit = {1'b1, 4'd0};
            7'b1001111: dec_digit = {1'b1, 4'd1};
            7'b0010010: dec_digit = {1'b1, 4'd2};
            7'b0000110: dec_digit = {1'b1, 4'd3};
            7'b1001100: dec_digit = {1'b1, 4'd4};
            7'b0100100: dec_digit = {1'b1, 4'd5};
            7'b0100000: dec_digit = {1'b1, 4'd6};
            7'b0001111: dec_digit = {1'b1, 4'd7};
            7'b0000000: dec_digit = {1'b1, 4'd8};
            7'b0000100: dec_digit = {1'b1, 4'd9};
            default:    dec_digit = {1'b0, 4'd0};
        endcase
    endfunction

    logic       same;
    logic       accept;
    logic [4:0] tens_dec, units_dec;
    logic [6:0] value_full;
    logic       legal;
    logic [3:0] hours_new;

    always_comb begin
        state_d     = state_q;
        sample_d    = sample_q;
        stab_cnt_d  = stab_cnt_q;
        out_valid_d = out_valid_q;
        hours_d     = hours_q;
        err_d       = err_q;
        last_d      = last_q;
        have_last_d = have_last_q;

        same = (bus.seg_in == sample_q);
        if (bus.sample_en) begin
            sample_d   = bus.seg_in;
            stab_cnt_d = !same ? 4'd1 :
                         (stab_cnt_q == 4'hF) ? 4'hF : stab_cnt_q + 4'd1;
        end

        // Acceptance fires only on the transition into STABLE_CNT; a reload
        // to 1 counts as a transition even if the count was already 1.
        accept = bus.sample_en && (stab_cnt_d == STABLE_CNT4) &&
                 (!same || (stab_cnt_q != stab_cnt_d));

        tens_dec   = dec_digit(bus.seg_in[13:7]);
        units_dec  = dec_digit(bus.seg_in[6:0]);
        value_full = 7'(tens_dec[3:0]) * 7'd10 + 7'(units_dec[3:0]);
        legal      = tens_dec[4] && units_dec[4] && (value_full <= 7'd12);
        hours_new  = value_full[3:0];

        if (accept) err_d = !legal;

        unique case (state_q)
            IDLE, TRACK: begin
                if (bus.sample_en) state_d = TRACK;
                if (accept && legal && (!have_last_q || hours_new != last_q)) begin
                    hours_d     = hours_new;
                    out_valid_d = 1'b1;
                    state_d     = PRESENT;
                end
            end
            PRESENT: begin
                // Legal acceptances are dropped here; only the handshake
                // moves us back to TRACK.
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    last_d      = hours_q;
                    have_last_d = 1'b1;
                    state_d     = TRACK;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sample_q    <= 14'h3FFF;
            stab_cnt_q  <= 4'd0;
            out_valid_q <= 1'b0;
            hours_q     <= 4'd0;
            err_q       <= 1'b0;
            last_q      <= 4'd0;
            have_last_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sample_q    <= sample_d;
            stab_cnt_q  <= stab_cnt_d;
            out_valid_q <= out_valid_d;
            hours_q     <= hours_d;
            err_q       <= err_d;
            last_q      <= last_d;
            have_last_q <= have_last_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.hours_bcd = hours_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_hours_segment_decoder.sv
// Bench for hours_segment_decoder: two instances (STABLE_CNT=3 and 1) share
// the same stimulus; each is compared every cycle against a run-length based
// reference model, plus directed expectations for the key scenarios.
module tb_hours_segment_decoder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hours_segment_decoder_if if3();
    hours_segment_decoder_if if1();

    hours_segment_decoder #(.STABLE_CNT(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));
    hours_segment_decoder #(.STABLE_CNT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

    int checks = 0;
    int errors = 0;
    logic rdy = 1'b1;

    // reference model state, index 0 = STABLE_CNT 3, index 1 = STABLE_CNT 1
    int          m_s [2] = '{3, 1};
    logic [13:0] m_prev [2];
    int          m_run [2];
    bit          m_valid [2];
    int          m_hours [2];
    bit          m_err [2];
    bit          m_have [2];
    int          m_last [2];

    function automatic logic [6:0] dig(input int d);
        case (d)
            0: dig = 7'b0000001; 1: dig = 7'b1001111; 2: dig = 7'b0010010;
            3: dig = 7'b0000110; 4: dig = 7'b1001100; 5: dig = 7'b0100100;
            6: dig = 7'b0100000; 7: dig = 7'b0001111; 8: dig = 7'b0000000;
            default: dig = 7'b0000100;
        endcase
    endfunction

    function automatic int mdec(input logic [6:0] p);
        mdec = -1;
        for (int i = 0; i < 10; i++) if (dig(i) == p) mdec = i;
    endfunction

    function automatic logic [13:0] pat(input int v);
        pat = {dig(v / 10), dig(v % 10)};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_prev[k] = 14'h3FFF; m_run[k] = 0; m_valid[k] = 0; m_hours[k] = 0;
            m_err[k] = 0; m_have[k] = 0; m_last[k] = 0;
        end
    endtask

    task automatic model_upd(input int k, input logic [13:0] seg, input bit en, input bit r);
        bit hs, acc, lg;
        int t, u, v;
        hs  = m_valid[k] && r;
        acc = 0;
        if (en) begin
            m_run[k]  = (seg == m_prev[k]) ? m_run[k] + 1 : 1;
            m_prev[k] = seg;
            acc       = (m_run[k] == m_s[k]);
        end
        t  = mdec(seg[13:7]);
        u  = mdec(seg[6:0]);
        v  = t * 10 + u;
        lg = (t >= 0) && (u >= 0) && (v <= 12);
        if (acc) begin
            m_err[k] = !lg;
            if (lg && !m_valid[k] && (!m_have[k] || v != m_last[k])) begin
                m_valid[k] = 1; m_hours[k] = v;
            end
        end
        if (hs) begin
            m_valid[k] = 0; m_last[k] = m_hours[k]; m_have[k] = 1;
        end
    endtask

    task automatic expect_eq(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        expect_eq("m3_valid", int'(if3.out_valid), int'(m_valid[0]));
        expect_eq("m3_hours", int'(if3.hours_bcd), m_hours[0]);
        expect_eq("m3_err",   int'(if3.err),       int'(m_err[0]));
        expect_eq("m1_valid", int'(if1.out_valid), int'(m_valid[1]));
        expect_eq("m1_hours", int'(if1.hours_bcd), m_hours[1]);
        expect_eq("m1_err",   int'(if1.err),       int'(m_err[1]));
    endtask

    task automatic step(input logic [13:0] seg, input bit en);
        if3.seg_in = seg; if3.sample_en = en; if3.out_ready = rdy;
        if1.seg_in = seg; if1.sample_en = en; if1.out_ready = rdy;
        @(posedge clk);
        model_upd(0, seg, en, rdy);
        model_upd(1, seg, en, rdy);
        #1;
        check_model();
    endtask

    task automatic idle();
        step(if3.seg_in, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    logic [13:0] rseg;
    int          r;

    initial begin
        if3.seg_in = '0; if3.sample_en = 0; if3.out_ready = 0;
        if1.seg_in = '0; if1.sample_en = 0; if1.out_ready = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        expect_eq("rst_valid", int'(if3.out_valid), 0);
        expect_eq("rst_hours", int'(if3.hours_bcd), 0);
        expect_eq("rst_err",   int'(if3.err), 0);
        check_model();
        rst_n = 1'b1;

        // 12 stable for three captures
        rdy = 1;
        step(14'b1001111_0010010, 1);
        expect_eq("s12_first_novalid", int'(if3.out_valid), 0);
        step(14'b1001111_0010010, 1);
        step(14'b1001111_0010010, 1);
        expect_eq("s12_valid", int'(if3.out_valid), 1);
        expect_eq("s12_hours", int'(if3.hours_bcd), 12);
        idle();
        expect_eq("s12_drop", int'(if3.out_valid), 0);

        // 5,5,7,7,7: only 7 reported
        step(pat(5), 1);
        expect_eq("s5_novalid", int'(if3.out_valid), 0);
        step(pat(5), 1);
        expect_eq("s5_novalid2", int'(if3.out_valid), 0);
        step(pat(7), 1);
        step(pat(7), 1);
        step(pat(7), 1);
        expect_eq("s7_valid", int'(if3.out_valid), 1);
        expect_eq("s7_hours", int'(if3.hours_bcd), 7);
        idle();

        // 13 is illegal, then 8 clears err
        for (int i = 0; i < 3; i++) step(14'b1001111_0000110, 1);
        expect_eq("s13_err", int'(if3.err), 1);
        expect_eq("s13_novalid", int'(if3.out_valid), 0);
        for (int i = 0; i < 3; i++) step(14'b0000001_0000000, 1);
        expect_eq("s8_valid", int'(if3.out_valid), 1);
        expect_eq("s8_hours", int'(if3.hours_bcd), 8);
        expect_eq("s8_err", int'(if3.err), 0);
        idle();

        // backpressure: 4 held while 9 goes stable
        rdy = 0;
        for (int i = 0; i < 3; i++) step(pat(4), 1);
        expect_eq("s4_valid", int'(if3.out_valid), 1);
        for (int i = 0; i < 5; i++) step(pat(9), 1);
        expect_eq("s4_hold_valid", int'(if3.out_valid), 1);
        expect_eq("s4_hold_hours", int'(if3.hours_bcd), 4);
        rdy = 1;
        idle();
        expect_eq("s4_xfer_drop", int'(if3.out_valid), 0);
        for (int i = 0; i < 3; i++) idle();
        expect_eq("s9_not_reported", int'(if3.out_valid), 0);

        // async reset while presenting 10
        rdy = 0;
        for (int i = 0; i < 3; i++) step(pat(10), 1);
        expect_eq("s10_valid", int'(if3.out_valid), 1);
        expect_eq("s10_hours", int'(if3.hours_bcd), 10);
        #2 rst_n = 1'b0;
        #1;
        expect_eq("async_rst_valid3", int'(if3.out_valid), 0);
        expect_eq("async_rst_valid1", int'(if1.out_valid), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        rdy = 1;
        for (int i = 0; i < 3; i++) step(pat(10), 1);
        expect_eq("s10_again_valid", int'(if3.out_valid), 1);
        expect_eq("s10_again_hours", int'(if3.hours_bcd), 10);
        idle();

        // STABLE_CNT=1: alternating 1,2,1
        do_reset();
        step(pat(1), 1);
        expect_eq("n1_a_valid", int'(if1.out_valid), 1);
        expect_eq("n1_a_hours", int'(if1.hours_bcd), 1);
        idle();
        expect_eq("n1_a_drop", int'(if1.out_valid), 0);
        step(pat(2), 1);
        expect_eq("n1_b_valid", int'(if1.out_valid), 1);
        expect_eq("n1_b_hours", int'(if1.hours_bcd), 2);
        idle();
        expect_eq("n1_b_drop", int'(if1.out_valid), 0);
        step(pat(1), 1);
        expect_eq("n1_c_valid", int'(if1.out_valid), 1);
        expect_eq("n1_c_hours", int'(if1.hours_bcd), 1);
        idle();
        expect_eq("n1_c_drop", int'(if1.out_valid), 0);

        // randomized phase, patterns held for a few samples to reach stability
        do_reset();
        rseg = pat(0);
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                r = int'($urandom_range(0, 9));
                if (r < 6)       rseg = pat(int'($urandom_range(0, 12)));
                else if (r < 8)  rseg = {dig(int'($urandom_range(0, 9))), dig(int'($urandom_range(0, 9)))};
                else             rseg = 14'($urandom);
            end
            rdy = ($urandom_range(0, 2) != 0);
            step(rseg, $urandom_range(0, 3) != 0);
            if (i == 300) do_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
